scratchpad_mem_banked: RTL and testbench

//  Parametrised successor of the 4-lane scratchpad: byte-lane banked data scratchpad for the Wildcat pipeline.

---
 rtl/spm_pkg.sv | 24 ++
 rtl/spm_lane.sv | 48 ++++
 rtl/scratchpad_mem_banked.sv | 127 ++++++++++++
 tb/tb_scratchpad_mem_banked.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the banked scratchpad.
package spm_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } spm_state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned lanes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Width of a word index into a lane of the given depth.
    function automatic int unsigned idx_w_of(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Number of byte-offset address bits covered by one word.
    function automatic int unsigned off_w_of(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 0;
    endfunction

endpackage

// File: rtl/spm_lane.sv
// One byte lane: 8-bit x DEPTH synchronous RAM, one write port, one registered
// read-before-write read port. Optional word-0 preload under SPM_PRELOAD_EN.
module spm_lane
    import spm_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [7:0]  INIT_BYTE = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [idx_w_of(DEPTH)-1:0] wr_idx,
    input  logic [7:0]                 wr_byte,
    input  logic                       re,
    input  logic                       rd_clr,
    input  logic [idx_w_of(DEPTH)-1:0] rd_idx,
    output logic [7:0]                 rd_byte
);

`ifdef SPM_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    logic [7:0] mem [DEPTH];

    // Storage write port; preload loads word 0 while reset is held.
    always_ff @(posedge clk) begin
        if (PRELOAD && !rst_n) begin
            mem[0] <= INIT_BYTE;
        end else if (we) begin
            mem[wr_idx] <= wr_byte;
        end
    end

    // Registered read; sees pre-write contents on a same-index collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_byte <= '0;
        end else if (re) begin
            rd_byte <= mem[rd_idx];
        end else if (rd_clr) begin
            rd_byte <= '0;
        end
    end

endmodule

// File: rtl/scratchpad_mem_banked.sv
// Byte-lane banked data scratchpad with zero-fill clear engine and sticky
// out-of-range detection. Define SPM_PRELOAD_EN to preload lanes and skip
// the clear engine.
module scratchpad_mem_banked
    import spm_pkg::*;
#(
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       ADDR_W        = 32,
    parameter int unsigned       DEPTH         = 4096,
    parameter logic [DATA_W-1:0] PRELOAD_WORD0 = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_rdEnable,
    input  logic [ADDR_W-1:0]           io_rdAddress,
    output logic [DATA_W-1:0]           io_rdData,
    output logic                        io_rdValid,
    input  logic [ADDR_W-1:0]           io_wrAddress,
    input  logic [DATA_W-1:0]           io_wrData,
    input  logic [lanes_of(DATA_W)-1:0] io_wrEnable,
    output logic                        io_ready,
    output logic                        io_error
);

    localparam int unsigned LANES  = lanes_of(DATA_W);
    localparam int unsigned IDX_W  = idx_w_of(DEPTH);
    localparam int unsigned OFF_W  = off_w_of(LANES);
    localparam int unsigned TOP_LSB = OFF_W + IDX_W;
`ifdef SPM_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    spm_state_e       state;
    spm_state_e       state_d;
    logic [IDX_W-1:0] clr_idx;
    logic             clearing;
    logic             run;
    logic             rd_oor;
    logic             wr_oor;
    logic             rd_accept;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign run       = (state == RUN);
    assign clearing  = (state == CLEAR) && !PRELOAD;
    assign rd_oor    = (io_rdAddress >> TOP_LSB) != '0;
    assign wr_oor    = (io_wrAddress >> TOP_LSB) != '0;
    assign rd_idx    = io_rdAddress[OFF_W +: IDX_W];
    assign wr_idx    = io_wrAddress[OFF_W +: IDX_W];
    assign rd_accept = run && io_rdEnable;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= state_d;
        end
    end

    // Next state: leave CLEAR after the last index is zeroed (or at once when preloaded).
    always_comb begin
        state_d = state;
        case (state)
            CLEAR: begin
                if (PRELOAD || (clr_idx == IDX_W'(DEPTH - 1))) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Clear index walks every word once while clearing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + IDX_W'(1);
        end
    end

    // Read-valid, ready and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_rdValid <= 1'b0;
            io_ready   <= 1'b0;
            io_error   <= 1'b0;
        end else begin
            io_rdValid <= rd_accept;
            io_ready   <= (state_d == RUN);
            if (run && ((io_rdEnable && rd_oor) || ((|io_wrEnable) && wr_oor))) begin
                io_error <= 1'b1;
            end
        end
    end

    // Lane array; write port muxed between the clear engine and user writes.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             lane_we;
        logic [IDX_W-1:0] lane_widx;
        logic [7:0]       lane_wbyte;

        assign lane_we    = clearing || (run && io_wrEnable[i] && !wr_oor);
        assign lane_widx  = clearing ? clr_idx : wr_idx;
        assign lane_wbyte = clearing ? 8'h00 : io_wrData[8*i +: 8];

        spm_lane #(
            .DEPTH     (DEPTH),
            .INIT_BYTE (PRELOAD_WORD0[8*i +: 8])
        ) u_lane (
            .clk     (clock),
            .rst_n   (reset),
            .we      (lane_we),
            .wr_idx  (lane_widx),
            .wr_byte (lane_wbyte),
            .re      (rd_accept && !rd_oor),
            .rd_clr  (rd_accept && rd_oor),
            .rd_idx  (rd_idx),
            .rd_byte (io_rdData[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_scratchpad_mem_banked.sv
// Self-checking bench for scratchpad_mem_banked (DATA_W=32, DEPTH=16).
module tb_scratchpad_mem_banked;

    localparam int unsigned DEPTH = 16;
`ifdef SPM_PRELOAD_EN
    localparam int unsigned READY_AT = 1;
`else
    localparam int unsigned READY_AT = DEPTH;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        io_rdEnable;
    logic [31:0] io_rdAddress;
    logic [31:0] io_rdData;
    logic        io_rdValid;
    logic [31:0] io_wrAddress;
    logic [31:0] io_wrData;
    logic [3:0]  io_wrEnable;
    logic        io_ready;
    logic        io_error;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_err;
    int          m_cnt;

    scratchpad_mem_banked #(
        .DATA_W        (32),
        .ADDR_W        (32),
        .DEPTH         (DEPTH),
        .PRELOAD_WORD0 (32'h44332211)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_rdEnable  (io_rdEnable),
        .io_rdAddress (io_rdAddress),
        .io_rdData    (io_rdData),
        .io_rdValid   (io_rdValid),
        .io_wrAddress (io_wrAddress),
        .io_wrData    (io_wrData),
        .io_wrEnable  (io_wrEnable),
        .io_ready     (io_ready),
        .io_error     (io_error)
    );

    always #5 clock = ~clock;

    task automatic idle();
        io_rdEnable  = 1'b0;
        io_rdAddress = '0;
        io_wrAddress = '0;
        io_wrData    = '0;
        io_wrEnable  = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
        return a;
    endfunction

    task automatic rand_inputs();
        io_rdEnable  = 1'($urandom_range(0, 1));
        io_rdAddress = rand_addr();
        io_wrAddress = rand_addr();
        io_wrData    = $urandom;
        io_wrEnable  = 4'($urandom_range(0, 15));
    endtask

    // Apply the memory rules to the current inputs, then advance one clock.
    task automatic tick();
        logic        oor;
        int          idx;
        if (!reset) begin
            m_cnt = 0; m_err = 1'b0; m_data = '0; m_valid = 1'b0;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        end else if (m_cnt < READY_AT) begin
            m_cnt++;
            m_valid = 1'b0;
        end else begin
            oor = (io_rdAddress >> 6) != 0;
            idx = int'((io_rdAddress >> 2) & 32'hF);
            m_valid = io_rdEnable;
            if (io_rdEnable) begin
                m_data = oor ? 32'h0 : m_mem[idx];
                if (oor) m_err = 1'b1;
            end
            oor = (io_wrAddress >> 6) != 0;
            idx = int'((io_wrAddress >> 2) & 32'hF);
            if (io_wrEnable != 0) begin
                if (oor) m_err = 1'b1;
                else for (int l = 0; l < 4; l++)
                    if (io_wrEnable[l]) m_mem[idx][8*l +: 8] = io_wrData[8*l +: 8];
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            tick();
            checks++;
            if ({io_ready, io_rdValid, io_error, io_rdData} !== 35'h0) begin
                errors++;
                $display("FAIL reset_state: ready=%b valid=%b err=%b data=%h required all zero",
                         io_ready, io_rdValid, io_error, io_rdData);
            end
        end
        reset = 1'b1;
        n = 0;
        while (io_ready !== 1'b1 && n < 40) begin
            rand_inputs();
            tick();
            n++;
            checks++;
            if (io_rdValid !== 1'b0 || io_error !== 1'b0) begin
                errors++;
                $display("FAIL clear_ignores: valid=%b err=%b required 0 0", io_rdValid, io_error);
            end
        end
        checks++;
        if (n != READY_AT) begin
            errors++;
            $display("FAIL ready_latency: cycles=%0d required %0d", n, READY_AT);
        end
        idle();
        io_rdEnable = 1'b1; io_rdAddress = 32'h14;
        tick();
        checks++;
        if (io_rdData !== 32'h0 || io_rdValid !== 1'b1) begin
            errors++;
            $display("FAIL read_after_clear: data=%h valid=%b required 00000000 1", io_rdData, io_rdValid);
        end
    endtask

    task automatic test_write_strobe();
        idle();
        io_wrAddress = 32'h10; io_wrData = 32'hDEADBEEF; io_wrEnable = 4'b1111;
        tick();
        io_wrData = 32'h000000AA; io_wrEnable = 4'b0001;
        tick();
        idle();
        io_rdEnable = 1'b1; io_rdAddress = 32'h10;
        tick();
        checks++;
        if (io_rdData !== 32'hDEADBEAA || io_rdData !== m_data || io_rdValid !== 1'b1) begin
            errors++;
            $display("FAIL write_strobe: data=%h valid=%b required deadbeaa 1", io_rdData, io_rdValid);
        end
        idle();
        tick();
        checks++;
        if (io_rdValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: valid=%b required 0", io_rdValid);
        end
    endtask

    task automatic test_read_before_write();
        idle();
        io_wrAddress = 32'h20; io_wrData = 32'h12345678; io_wrEnable = 4'b1111;
        io_rdEnable = 1'b1; io_rdAddress = 32'h20;
        tick();
        checks++;
        if (io_rdData !== 32'h0 || io_rdValid !== 1'b1) begin
            errors++;
            $display("FAIL rbw_old: data=%h required 00000000", io_rdData);
        end
        idle();
        io_rdEnable = 1'b1; io_rdAddress = 32'h23;
        tick();
        checks++;
        if (io_rdData !== 32'h12345678) begin
            errors++;
            $display("FAIL rbw_new: data=%h required 12345678", io_rdData);
        end
    endtask

    task automatic test_hold();
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (io_rdData !== 32'h12345678 || io_rdValid !== 1'b0) begin
                errors++;
                $display("FAIL data_hold: data=%h valid=%b required 12345678 0", io_rdData, io_rdValid);
            end
        end
    endtask

    task automatic test_out_of_range();
        checks++;
        if (io_error !== 1'b0) begin
            errors++;
            $display("FAIL error_clean: err=%b required 0", io_error);
        end
        idle();
        io_rdEnable = 1'b1; io_rdAddress = 32'h40;
        tick();
        checks++;
        if (io_rdData !== 32'h0 || io_rdValid !== 1'b1 || io_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: data=%h valid=%b err=%b required 00000000 1 1",
                     io_rdData, io_rdValid, io_error);
        end
        idle();
        io_wrAddress = 32'h40; io_wrData = 32'hFFFFFFFF; io_wrEnable = 4'b1111;
        tick();
        idle();
        io_rdEnable = 1'b1; io_rdAddress = 32'h0;
        tick();
        checks++;
        if (io_rdData !== 32'h0 || io_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_no_alias: data=%h err=%b required 00000000 1", io_rdData, io_error);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            tick();
            checks++;
            if (io_rdData !== m_data || io_rdValid !== m_valid || io_error !== m_err || io_ready !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d]: data=%h valid=%b err=%b ready=%b required %h %b %b 1",
                         c, io_rdData, io_rdValid, io_error, io_ready, m_data, m_valid, m_err);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            idle();
            io_wrAddress = 32'h10; io_wrData = 32'hA5A5A5A5; io_wrEnable = 4'b1111;
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n = 0;
        while (io_ready !== 1'b1 && n < 40) begin
            idle();
            io_wrAddress = 32'h20; io_wrData = $urandom; io_wrEnable = 4'b1111;
            tick();
            n++;
        end
        checks++;
        if (n != READY_AT) begin
            errors++;
            $display("FAIL restart_latency: cycles=%0d required %0d", n, READY_AT);
        end
        for (int a = 0; a < 2; a++) begin
            idle();
            io_rdEnable = 1'b1; io_rdAddress = (a == 0) ? 32'h10 : 32'h20;
            tick();
            checks++;
            if (io_rdData !== 32'h0 || io_rdValid !== 1'b1 || io_error !== 1'b0) begin
                errors++;
                $display("FAIL restart_cleared[%0d]: data=%h valid=%b err=%b required 00000000 1 0",
                         a, io_rdData, io_rdValid, io_error);
            end
        end
    endtask

`ifdef SPM_PRELOAD_EN
    task automatic test_preload();
        idle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (io_ready !== 1'b1) begin
            errors++;
            $display("FAIL preload_ready: ready=%b required 1", io_ready);
        end
        io_rdEnable = 1'b1; io_rdAddress = 32'h0;
        tick();
        checks++;
        if (io_rdData !== 32'h44332211) begin
            errors++;
            $display("FAIL preload_word0: data=%h required 44332211", io_rdData);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        idle();
`ifdef SPM_PRELOAD_EN
        test_preload();
`else
        test_reset();
        test_write_strobe();
        test_read_before_write();
        test_hold();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
